// File: rtl/fpmul_sched.sv
// Round-robin scheduler sharing one single-precision multiplier among NREQ requesters.
// Accepted operations flow through a fixed LAT-cycle pipeline and return tagged to their source.
module fpmul_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  parameter int CW   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      ReqValid,
  input  logic [32*NREQ-1:0]   ReqA,
  input  logic [32*NREQ-1:0]   ReqB,
  output logic [NREQ-1:0]      ReqReady,
  output logic [NREQ-1:0]      RespValid,
  output logic [31:0]          Result,
  output logic                 Busy,
  output logic [CW-1:0]        OpCount
);

  localparam int TW = $clog2(NREQ);

  // Truncating multiply with no special cases: exponent and fraction simply wrap.
  function automatic logic [31:0] fpMul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] mant;
    logic [7:0]  expo;
    logic [22:0] frac;
    mant = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    expo = a[30:23] + b[30:23] - 8'd127;
    if (mant[47]) begin
      expo = expo + 8'd1;
      frac = mant[46:24];
    end else begin
      frac = mant[45:23];
    end
    return {a[31] ^ b[31], expo, frac};
  endfunction

  logic [TW-1:0] ptr;
  logic [TW-1:0] ptrNext;
  logic [TW-1:0] grantIdx;
  logic          grantAny;
  logic [TW:0]   idx;

  always_comb begin
    ReqReady = '0;
    grantAny = 1'b0;
    grantIdx = '0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (TW+1)'(k);
      if (idx >= (TW+1)'(NREQ)) idx = idx - (TW+1)'(NREQ);
      if (!grantAny && ReqValid[idx[TW-1:0]]) begin
        grantAny = 1'b1;
        grantIdx = idx[TW-1:0];
      end
    end
    if (rst) grantAny = 1'b0;
    if (grantAny) ReqReady[grantIdx] = 1'b1;
  end

  assign ptrNext = (grantIdx == TW'(NREQ-1)) ? '0 : grantIdx + 1'b1;

  // Stage 1: capture accepted operands and tag
  logic [31:0]   opA_p1;
  logic [31:0]   opB_p1;
  logic [TW-1:0] tag_p1;
  logic          vld_p1;
  logic [31:0]   prod_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      OpCount <= '0;
      vld_p1  <= 1'b0;
      opA_p1  <= '0;
      opB_p1  <= '0;
      tag_p1  <= '0;
    end else begin
      vld_p1 <= grantAny;
      if (grantAny) begin
        opA_p1  <= ReqA[32*grantIdx +: 32];
        opB_p1  <= ReqB[32*grantIdx +: 32];
        tag_p1  <= grantIdx;
        ptr     <= ptrNext;
        OpCount <= OpCount + 1'b1;
      end
    end
  end

  assign prod_p1 = fpMul(opA_p1, opB_p1);

  logic [31:0]   prodLast;
  logic [TW-1:0] tagLast;
  logic          vldLast;
  logic          tailBusy;

  if (LAT == 1) begin : gDirect
    assign prodLast = prod_p1;
    assign tagLast  = tag_p1;
    assign vldLast  = vld_p1;
    assign tailBusy = 1'b0;
  end else begin : gPipe
    // Stages 2..LAT: delay product, tag and valid together
    logic [31:0]   prodQ [LAT-1];
    logic [TW-1:0] tagQ  [LAT-1];
    logic [LAT-2:0] vldQ;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vldQ <= '0;
        for (int k = 0; k < LAT-1; k++) begin
          prodQ[k] <= '0;
          tagQ[k]  <= '0;
        end
      end else begin
        prodQ[0] <= prod_p1;
        tagQ[0]  <= tag_p1;
        vldQ[0]  <= vld_p1;
        for (int k = 1; k < LAT-1; k++) begin
          prodQ[k] <= prodQ[k-1];
          tagQ[k]  <= tagQ[k-1];
          vldQ[k]  <= vldQ[k-1];
        end
      end
    end

    assign prodLast = prodQ[LAT-2];
    assign tagLast  = tagQ[LAT-2];
    assign vldLast  = vldQ[LAT-2];
    assign tailBusy = |vldQ;
  end

  assign RespValid = vldLast ? (NREQ'(1) << tagLast) : '0;
  assign Result    = vldLast ? prodLast : '0;
  assign Busy      = vld_p1 | tailBusy;

endmodule

// File: tb/tb_fpmul_sched.sv
// Randomized bench for fpmul_sched against a queue-based reference of grants and responses.
module tb_fpmul_sched;
  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int CW   = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     ReqValid;
  logic [32*NREQ-1:0]  ReqA;
  logic [32*NREQ-1:0]  ReqB;
  logic [NREQ-1:0]     ReqReady;
  logic [NREQ-1:0]     RespValid;
  logic [31:0]         Result;
  logic                Busy;
  logic [CW-1:0]       OpCount;

  fpmul_sched #(.NREQ(NREQ), .LAT(LAT), .CW(CW)) dut (
    .clk(clk), .rst(rst), .ReqValid(ReqValid), .ReqA(ReqA), .ReqB(ReqB),
    .ReqReady(ReqReady), .RespValid(RespValid), .Result(Result),
    .Busy(Busy), .OpCount(OpCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          tag;
    logic [31:0] val;
  } resp_t;

  resp_t pend[$];
  int mPtr = 0;
  int mCount = 0;
  int edgeN = 0;
  int errCnt = 0;
  int chkCnt = 0;
  logic [31:0] pool [8] = '{32'h40000000, 32'h40400000, 32'h3FC00000, 32'hC0000000,
                            32'h3F800000, 32'h00000000, 32'h7F800000, 32'hBF000000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, edgeN);
    end
  endtask

  // Reference multiply from the arithmetic rules, using wide integer math.
  function automatic logic [31:0] refMul(input logic [31:0] a, input logic [31:0] b);
    longint unsigned ma, mb, p;
    int e;
    logic [22:0] f;
    ma = 64'h800000 | longint'(a[22:0]);
    mb = 64'h800000 | longint'(b[22:0]);
    p  = ma * mb;
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p >= 64'h8000_0000_0000) begin
      e = e + 1;
      f = 23'(p >> 24);
    end else begin
      f = 23'(p >> 23);
    end
    return {a[31] ^ b[31], 8'(e), f};
  endfunction

  function automatic int refGrant(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[(mPtr + k) % NREQ]) return (mPtr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [127:0] pk(input logic [31:0] x0, input logic [31:0] x1,
                                      input logic [31:0] x2, input logic [31:0] x3);
    return {x3, x2, x1, x0};
  endfunction

  // One clock cycle: drive, check grant, advance model, check outputs.
  task automatic cycle(input logic [NREQ-1:0] v, input logic [127:0] a, input logic [127:0] b);
    int g;
    resp_t r;
    logic [31:0] expResp, expRes;
    ReqValid = v; ReqA = a; ReqB = b;
    #1;
    g = refGrant(v);
    chk("ReqReady", 32'(ReqReady), (g < 0) ? 32'd0 : 32'(1 << g));
    @(posedge clk);
    edgeN++;
    if (g >= 0) begin
      r.due = edgeN + LAT - 1;
      r.tag = g;
      r.val = refMul(a[32*g +: 32], b[32*g +: 32]);
      pend.push_back(r);
      mPtr = (g + 1) % NREQ;
      mCount = (mCount + 1) % (1 << CW);
    end
    @(negedge clk);
    expResp = 0;
    expRes  = 0;
    if (pend.size() > 0 && pend[0].due == edgeN) begin
      expResp = 32'(1 << pend[0].tag);
      expRes  = pend[0].val;
    end
    chk("RespValid", 32'(RespValid), expResp);
    chk("Result", Result, expRes);
    chk("Busy", 32'(Busy), 32'(pend.size() > 0));
    chk("OpCount", 32'(OpCount), 32'(mCount));
    if (pend.size() > 0 && pend[0].due == edgeN) void'(pend.pop_front());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, '0);
  endtask

  // Asynchronous reset asserted between edges, with requests pending.
  task automatic resetMid();
    ReqValid = '1;
    #2 rst = 1'b1;
    #1;
    chk("rstReady", 32'(ReqReady), 32'd0);
    chk("rstResp", 32'(RespValid), 32'd0);
    chk("rstResult", Result, 32'd0);
    chk("rstBusy", 32'(Busy), 32'd0);
    chk("rstCount", 32'(OpCount), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rstHoldResp", 32'(RespValid), 32'd0);
    rst = 1'b0;
    pend.delete();
    mPtr = 0;
    mCount = 0;
  endtask

  initial begin
    logic [127:0] ra, rb;
    logic [NREQ-1:0] rv;
    rst = 1'b1; ReqValid = '0; ReqA = '0; ReqB = '0;
    @(negedge clk);
    @(negedge clk);
    chk("initResp", 32'(RespValid), 32'd0);
    chk("initBusy", 32'(Busy), 32'd0);
    chk("initCount", 32'(OpCount), 32'd0);
    rst = 1'b0;

    // Single op and normalize/sign paths
    cycle(4'b0001, pk(32'h40000000, 0, 0, 0), pk(32'h40400000, 0, 0, 0));
    idle(3);
    cycle(4'b0100, pk(0, 0, 32'h3FC00000, 0), pk(0, 0, 32'h3FC00000, 0));
    cycle(4'b0010, pk(0, 32'hC0000000, 0, 0), pk(0, 32'h40400000, 0, 0));
    idle(3);

    // Fairness from pointer 0
    resetMid();
    for (int i = 0; i < 8; i++)
      cycle(4'b1111, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    idle(3);

    // Pointer skip
    resetMid();
    cycle(4'b0001, pk(32'h3F800000, 0, 0, 0), pk(32'h40000000, 0, 0, 0));
    cycle(4'b1001, pk(32'h40000000, 0, 0, 32'h40400000), pk(32'h40000000, 0, 0, 32'h40400000));
    cycle(4'b1001, pk(32'h40000000, 0, 0, 32'h40400000), pk(32'h40400000, 0, 0, 32'h40000000));
    idle(3);

    // Back-to-back responses to requester 1
    cycle(4'b0010, pk(0, 32'h40000000, 0, 0), pk(0, 32'h40000000, 0, 0));
    cycle(4'b0010, pk(0, 32'h40000000, 0, 0), pk(0, 32'h40400000, 0, 0));
    cycle(4'b0010, pk(0, 32'h40400000, 0, 0), pk(0, 32'h40400000, 0, 0));
    idle(3);

    // Reset with operations in flight, then a clean op
    cycle(4'b1111, {4{32'h40000000}}, {4{32'h40400000}});
    cycle(4'b1111, {4{32'h3FC00000}}, {4{32'h3FC00000}});
    resetMid();
    idle(2);
    cycle(4'b0100, pk(0, 0, 32'hC0000000, 0), pk(0, 0, 32'hBF000000, 0));
    idle(3);

    // Random traffic, including OpCount wrap
    for (int i = 0; i < 400; i++) begin
      rv = NREQ'($urandom);
      for (int j = 0; j < NREQ; j++) begin
        ra[32*j +: 32] = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
        rb[32*j +: 32] = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
      end
      cycle(rv, ra, rb);
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule

// File: doc/fpmul_sched.md
Name: fpmul_sched

Overview:
- Shares one single-precision floating-point multiplier datapath between NREQ requesters.
- Arbitrates among requesters round-robin and accepts at most one operation per cycle.
- Pushes each accepted operation through a fixed-latency pipeline with a requester tag.
- Returns each result to its originating requester as a one-hot response pulse. Sits between the compute clients and the shared multiplier.

Parameters:
- NREQ, default 4: number of requesters, 2..8.
- LAT, default 2: cycles from acceptance to response, LAT >= 1.
- CW, default 16: width of the accepted-operation counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ReqValid  input  NREQ  per-requester operation valid.
- ReqA  input  32*NREQ  operand A; requester i occupies bits [32i+31:32i].
- ReqB  input  32*NREQ  operand B; same packing as ReqA.
- ReqReady  output  NREQ  one-hot grant; the operation is accepted when ReqValid[i] & ReqReady[i].
- RespValid  output  NREQ  one-hot, one-cycle pulse marking the destination of Result.
- Result  output  32  product, valid while any RespValid bit is high.
- Busy  output  1  high while any operation is in flight.
- OpCount  output  CW  total accepted operations, wraps modulo 2^CW.

Behaviour:
- Reset values (asynchronous, active on rst high):
  - RespValid = 0, Result = 0, Busy = 0, OpCount = 0.
  - Round-robin pointer = 0.
  - All pipeline valid bits cleared; data registers cleared to 0.
  - ReqReady = 0 while rst is high.
- Arbitration:
  - ReqReady is combinational from ReqValid and the pointer.
  - Search order is index ptr, ptr+1, ..., wrapping modulo NREQ. The first index with ReqValid high gets ReqReady.
  - At most one ReqReady bit is high. ReqReady is 0 when ReqValid = 0.
  - Requesters may drop ReqValid while it is not granted; no penalty applies.
- Pointer update: on acceptance of index g, ptr <= (g+1) mod NREQ. With no acceptance, ptr holds.
- No backpressure:
  - The pipeline never stalls, so one acceptance per cycle is always possible.
  - Requesters must sink RespValid unconditionally.
- Pipeline:
  - Stage 1 registers the operands, the tag (index g) and valid at the acceptance edge.
  - The combinational multiplier computes from stage 1.
  - LAT-1 further stages register product, tag and valid.
  - If LAT = 1, the multiplier output feeds Result directly from stage 1.
  - Acceptance at edge t gives RespValid[g] high in the cycle after edge t+LAT-1, i.e. exactly LAT cycles later.
  - Results return in acceptance order.
- Outputs:
  - RespValid = valid_last ? (1 << tag_last) : 0.
  - Result = product_last when valid_last, else 0.
- Arithmetic (identical to the team's combinational fpmul):
  - Sign = SA^SB.
  - Mantissa product = {1,FracA} * {1,FracB}, 48 bits.
  - Exponent = ExpA + ExpB - 127, modulo 8 bits.
  - If product bit 47 is set: exponent + 1, fraction = product[46:24]. Otherwise fraction = product[45:23].
  - Truncation only; no rounding.
  - No special-case handling: zero, subnormal, inf, NaN, overflow and underflow wrap exactly as this arithmetic gives.
- Busy = OR of all pipeline valid bits. Acceptance in the current cycle is not included.
- OpCount increments by 1 on each acceptance and wraps from 2^CW-1 to 0.
- Simultaneous events:
  - Acceptance and response in the same cycle are independent.
  - A requester may be granted again while its earlier op is in flight.
  - Responses to the same requester in consecutive cycles are allowed.
- Reset mid-operation: all in-flight operations are discarded and no response is produced for them. The pointer and OpCount return to 0.

Test Plan:
- Single op: requester 0 sends A=0x40000000 (2.0), B=0x40400000 (3.0) with LAT=2 -> RespValid=0001 and Result=0x40C00000 exactly 2 cycles after acceptance; Busy high for those 2 cycles; OpCount=1.
- Normalize path: requester 2 sends 0x3FC00000 * 0x3FC00000 (1.5*1.5) -> Result=0x40100000 on RespValid=0100. Requester 1 sends 0xC0000000 * 0x40400000 (-2*3) -> Result=0xC0C00000.
- Round-robin fairness: all 4 ReqValid held high for 8 cycles -> grants 0,1,2,3,0,1,2,3; responses in the same order, one per cycle, LAT cycles delayed; OpCount=8.
- Pointer skip: ptr=1, ReqValid=1001 -> requester 3 granted, ptr becomes 0; next cycle with ReqValid=1001 -> requester 0 granted.
- Back-to-back same requester: only requester 1 valid for 3 cycles with products 2*2, 2*3, 3*3 -> RespValid=0010 on 3 consecutive cycles with 0x40800000, 0x40C00000, 0x41100000.
- Reset mid-flight: accept 2 ops, assert rst before either response -> no RespValid ever fires for them; OpCount=0, Busy=0, ptr=0; a new op after release completes normally.
